// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// hazard-detection helpers that the forwarding unit also reuses.
package pipeline_hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: the ID instruction reads a register that a load in EX writes.
// Latency: combinational; no backpressure of its own.
module load_use_detect
  import pipeline_hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  lu_hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard_o = ex_mem_read_i && (ex_rd_i != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: post-reset hold, load-use bubbles, branch flushes, dmem stalls.
// Latency: outputs combinational from state and inputs; backpressure: freezes on dmem req without ack.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  id_branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  stall_all_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu_hazard;
  logic             mstall;

  load_use_detect u_load_use_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_mem_read_i),
    .lu_hazard_o   (lu_hazard)
  );

  assign mstall = dmem_req_i & ~dmem_ack_i;

  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b1;
    id_ex_bubble_o = 1'b1;
    stall_all_o    = 1'b1;
    if (state_q == RUN || state_q == MEM_WAIT) begin
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      stall_all_o    = 1'b0;
      if (mstall) begin
        stall_all_o = 1'b1;
      end else if (lu_hazard) begin
        id_ex_bubble_o = 1'b1;
      end else if (id_branch_taken_i) begin
        // IF/ID stays enabled so it actually captures the NOP.
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b1;
      end else begin
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        if (mstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mstall) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (!pc_write_o) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (if_id_flush_o) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl with a queue-based scoreboard.
module tb_pipeline_hazard_ctrl;

  localparam int HOLD_CYCLES = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [4:0]       id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic             id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0, ex_mem_read_i = 1'b0;
  logic             id_branch_taken_i = 1'b0, dmem_req_i = 1'b0, dmem_ack_i = 1'b0;
  logic             pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, stall_all_o, mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  pipeline_hazard_ctrl #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_use_rs1_i      (id_use_rs1_i),
    .id_use_rs2_i      (id_use_rs2_i),
    .ex_rd_i           (ex_rd_i),
    .ex_mem_read_i     (ex_mem_read_i),
    .id_branch_taken_i (id_branch_taken_i),
    .dmem_req_i        (dmem_req_i),
    .dmem_ack_i        (dmem_ack_i),
    .pc_write_o        (pc_write_o),
    .if_id_write_o     (if_id_write_o),
    .if_id_flush_o     (if_id_flush_o),
    .id_ex_bubble_o    (id_ex_bubble_o),
    .stall_all_o       (stall_all_o),
    .mem_err_o         (mem_err_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             pc;
    logic             ifw;
    logic             fl;
    logic             bub;
    logic             st;
    logic             err;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: cycles of hold left, whether a memory wait is in progress,
  // how many stalled wait cycles have elapsed, and the sticky error.
  int               m_hold_left = HOLD_CYCLES;
  int               m_waited    = 0;
  bit               m_in_wait   = 1'b0;
  bit               m_err       = 1'b0;
  logic [CNT_W-1:0] m_stall     = '0;
  logic [CNT_W-1:0] m_flush     = '0;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                      input logic br, input logic req, input logic ack);
    obs_t e;
    bit   lu, ms;
    @(posedge clk_i);
    #1;
    rst_i = rst; id_rs1_i = rs1; id_rs2_i = rs2; ex_rd_i = rd;
    id_use_rs1_i = u1; id_use_rs2_i = u2; ex_mem_read_i = mr;
    id_branch_taken_i = br; dmem_req_i = req; dmem_ack_i = ack;
    e = '0;
    if (!rst) begin
      m_hold_left = HOLD_CYCLES; m_waited = 0; m_in_wait = 1'b0; m_err = 1'b0;
      m_stall = '0; m_flush = '0;
      e.fl = 1'b1; e.bub = 1'b1; e.st = 1'b1;
    end else begin
      lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      ms = req && !ack;
      e.err = m_err; e.sc = m_stall; e.fc = m_flush;
      if (m_hold_left > 0 || m_err) begin
        e.fl = 1'b1; e.bub = 1'b1; e.st = 1'b1;
      end else if (ms) begin
        e.st = 1'b1;
      end else if (lu) begin
        e.bub = 1'b1;
      end else if (br) begin
        e.pc = 1'b1; e.ifw = 1'b1; e.fl = 1'b1;
      end else begin
        e.pc = 1'b1; e.ifw = 1'b1;
      end
      if (!e.pc) m_stall = m_stall + 1'b1;
      if (e.fl) m_flush = m_flush + 1'b1;
      if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (!m_err) begin
        if (m_in_wait) begin
          if (ms) begin
            m_waited++;
            if (m_waited == MEM_TIMEOUT) m_err = 1'b1;
          end else begin
            m_in_wait = 1'b0;
          end
        end else if (ms) begin
          m_in_wait = 1'b1;
          m_waited  = 0;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic rst);
    step(rst, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_and_release();
    idle(1'b0);
    idle(1'b0);
    repeat (HOLD_CYCLES + 1) idle(1'b1);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, stall_all_o,
             mem_err_o, stall_cnt_o, flush_cnt_o};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got pc%b ifw%b fl%b bub%b st%b err%b sc%0d fc%0d exp pc%b ifw%b fl%b bub%b st%b err%b sc%0d fc%0d",
                   $time, a.pc, a.ifw, a.fl, a.bub, a.st, a.err, a.sc, a.fc,
                   e.pc, e.ifw, e.fl, e.bub, e.st, e.err, e.sc, e.fc);
        end
      end
    end
  end

  initial begin : stimulus
    reset_and_release();
    // Load-use on rs2, then the same with x0 as destination.
    step(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Branch alone, then branch together with a load-use hazard.
    step(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 5'd7, 5'd4, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    // Memory ack on the third cycle, then req and ack together.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    // Reset asserted mid-stall.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (HOLD_CYCLES + 1) idle(1'b1);
    // Timeout: ack never arrives, then other inputs must not wake it up.
    repeat (MEM_TIMEOUT + 3) step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    reset_and_release();
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
    end
    idle(1'b1);
    repeat (3) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
